ps2_direction_decoder: RTL and testbench

Converts the raw PS/2 Set-2 byte stream from `PS2_Controller` (`received_data` / `received_data_en`) into a registered, one-hot four-way direction for the game logic. It decodes make codes, break (`F0`) codes and extended (`E0`) prefixes, so both WASD and the arrow keys work. It tracks which keys are held and supports a sticky mode or a hold-to-move mode. It sits between `PS2_Controller` and the Pac-Man movement FSM.

---
 rtl/ps2_direction_decoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_direction_decoder.sv
// PS/2 Set-2 byte stream to one-hot four-way direction for the game FSM.
// Handles E0/F0 prefixes, WASD and arrow keys, and sticky or hold-to-move modes.
module ps2_direction_decoder #(
  parameter bit         STICKY         = 1'b1,
  parameter bit         ARROW_EN       = 1'b1,
  parameter logic [7:0] KEY_UP         = 8'h1D,
  parameter logic [7:0] KEY_DOWN       = 8'h1B,
  parameter logic [7:0] KEY_LEFT       = 8'h1C,
  parameter logic [7:0] KEY_RIGHT      = 8'h23,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       goup,
  output logic       godown,
  output logic       goleft,
  output logic       goright,
  output logic       dir_valid,
  output logic [3:0] held,
  output logic       key_event
);

  localparam int         CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] ARR_UP    = 8'h75;
  localparam logic [7:0] ARR_DOWN  = 8'h72;
  localparam logic [7:0] ARR_LEFT  = 8'h6B;
  localparam logic [7:0] ARR_RIGHT = 8'h74;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_held_n;
  logic [3:0]      r_held_e;
  logic [1:0]      r_dir;
  logic            r_vld;
  logic [3:0]      r_go;
  logic [3:0]      r_held_o;
  logic            r_kev;

  logic            w_make;
  logic            w_brk;
  logic            w_ext;
  logic            w_hit;
  logic [1:0]      w_idx;
  logic            w_src_prev;
  logic            w_mk_ev;
  logic            w_bk_ev;
  logic [3:0]      w_held_n_nx;
  logic [3:0]      w_held_e_nx;
  logic [3:0]      w_held_nx;
  logic [1:0]      w_dir_nx;
  logic            w_vld_nx;
  logic [2:0]      w_pick;
  logic [3:0]      w_go_nx;

  // Bit index 3..0 = up, down, left, right; returns {valid, index} by that priority.
  function automatic logic [2:0] pick_dir(input logic [3:0] h);
    logic [2:0] res;
    if (h[3]) begin
      res = {1'b1, 2'd3};
    end else if (h[2]) begin
      res = {1'b1, 2'd2};
    end else if (h[1]) begin
      res = {1'b1, 2'd1};
    end else if (h[0]) begin
      res = {1'b1, 2'd0};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Classify the strobed byte as a make or break event from the current prefix state.
  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    if (ps2_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          w_make = (ps2_byte != CODE_EXT) && (ps2_byte != CODE_BRK);
        end
        S_EXT: begin
          w_make = (ps2_byte != CODE_EXT) && (ps2_byte != CODE_BRK);
          w_ext  = 1'b1;
        end
        S_BRK: begin
          w_brk = 1'b1;
        end
        S_EXT_BRK: begin
          w_brk = 1'b1;
          w_ext = 1'b1;
        end
        default: begin
          w_make = 1'b0;
        end
      endcase
    end else begin
      w_make = 1'b0;
    end
  end

  // Map the byte to a direction index for its source.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 2'd0;
    if (w_ext) begin
      if (ARROW_EN) begin
        case (ps2_byte)
          ARR_UP:    begin w_hit = 1'b1; w_idx = 2'd3; end
          ARR_DOWN:  begin w_hit = 1'b1; w_idx = 2'd2; end
          ARR_LEFT:  begin w_hit = 1'b1; w_idx = 2'd1; end
          ARR_RIGHT: begin w_hit = 1'b1; w_idx = 2'd0; end
          default:   begin w_hit = 1'b0; end
        endcase
      end else begin
        w_hit = 1'b0;
      end
    end else begin
      case (ps2_byte)
        KEY_UP:    begin w_hit = 1'b1; w_idx = 2'd3; end
        KEY_DOWN:  begin w_hit = 1'b1; w_idx = 2'd2; end
        KEY_LEFT:  begin w_hit = 1'b1; w_idx = 2'd1; end
        KEY_RIGHT: begin w_hit = 1'b1; w_idx = 2'd0; end
        default:   begin w_hit = 1'b0; end
      endcase
    end
  end

  assign w_src_prev = w_ext ? r_held_e[w_idx] : r_held_n[w_idx];
  assign w_mk_ev    = w_make & w_hit;
  // A break of a key that is not held is dropped entirely.
  assign w_bk_ev    = w_brk & w_hit & w_src_prev;

  // Next held bits for both sources.
  always_comb begin
    w_held_n_nx = r_held_n;
    w_held_e_nx = r_held_e;
    if (w_mk_ev) begin
      if (w_ext) begin
        w_held_e_nx[w_idx] = 1'b1;
      end else begin
        w_held_n_nx[w_idx] = 1'b1;
      end
    end else if (w_bk_ev) begin
      if (w_ext) begin
        w_held_e_nx[w_idx] = 1'b0;
      end else begin
        w_held_n_nx[w_idx] = 1'b0;
      end
    end else begin
      w_held_n_nx = r_held_n;
    end
  end

  assign w_held_nx = w_held_n_nx | w_held_e_nx;
  assign w_pick    = pick_dir(w_held_nx);

  // Next direction: latest make wins; in hold mode releasing the active key re-selects.
  always_comb begin
    w_dir_nx = r_dir;
    w_vld_nx = r_vld;
    if (w_mk_ev) begin
      w_dir_nx = w_idx;
      w_vld_nx = 1'b1;
    end else if (w_bk_ev && !STICKY && r_vld && (r_dir == w_idx) && !w_held_nx[w_idx]) begin
      w_vld_nx = w_pick[2];
      w_dir_nx = w_pick[1:0];
    end else begin
      w_dir_nx = r_dir;
    end
  end

  assign w_go_nx = w_vld_nx ? (4'b0001 << w_dir_nx) : 4'b0000;

  // Prefix FSM with idle timeout; a byte on the timeout cycle is still decoded.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (ps2_byte_valid) begin
      r_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (ps2_byte == CODE_EXT) begin
            r_state <= S_EXT;
          end else if (ps2_byte == CODE_BRK) begin
            r_state <= S_BRK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXT: begin
          if (ps2_byte == CODE_BRK) begin
            r_state <= S_EXT_BRK;
          end else if (ps2_byte == CODE_EXT) begin
            r_state <= S_EXT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_cnt == CNT_LAST) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Held bits, direction register and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_held_n <= 4'b0000;
      r_held_e <= 4'b0000;
      r_dir    <= 2'd0;
      r_vld    <= 1'b0;
      r_go     <= 4'b0000;
      r_held_o <= 4'b0000;
      r_kev    <= 1'b0;
    end else begin
      r_held_n <= w_held_n_nx;
      r_held_e <= w_held_e_nx;
      r_dir    <= w_dir_nx;
      r_vld    <= w_vld_nx;
      r_go     <= w_go_nx;
      r_held_o <= w_held_nx;
      r_kev    <= w_mk_ev & ~w_src_prev;
    end
  end

  assign goup      = r_go[3];
  assign godown    = r_go[2];
  assign goleft    = r_go[1];
  assign goright   = r_go[0];
  assign dir_valid = r_vld;
  assign held      = r_held_o;
  assign key_event = r_kev;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Bench for ps2_direction_decoder: three instances (hold mode, sticky mode, arrows off)
// driven by one byte stream; directed table, corner sequences and a random reference run.
module tb_ps2_direction_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ps2_byte;
  logic       ps2_vld;
  logic [2:0] o_up, o_dn, o_lf, o_rt, o_dv, o_ke;
  logic [3:0] o_held [3];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ps2_direction_decoder #(.STICKY(1'b0), .ARROW_EN(1'b1), .TIMEOUT_CYCLES(TO)) u_s0 (
    .CLOCK_50(clk), .reset(rst_n), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_vld),
    .goup(o_up[0]), .godown(o_dn[0]), .goleft(o_lf[0]), .goright(o_rt[0]),
    .dir_valid(o_dv[0]), .held(o_held[0]), .key_event(o_ke[0]));

  ps2_direction_decoder #(.STICKY(1'b1), .ARROW_EN(1'b1), .TIMEOUT_CYCLES(TO)) u_s1 (
    .CLOCK_50(clk), .reset(rst_n), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_vld),
    .goup(o_up[1]), .godown(o_dn[1]), .goleft(o_lf[1]), .goright(o_rt[1]),
    .dir_valid(o_dv[1]), .held(o_held[1]), .key_event(o_ke[1]));

  ps2_direction_decoder #(.STICKY(1'b0), .ARROW_EN(1'b0), .TIMEOUT_CYCLES(TO)) u_na (
    .CLOCK_50(clk), .reset(rst_n), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_vld),
    .goup(o_up[2]), .godown(o_dn[2]), .goleft(o_lf[2]), .goright(o_rt[2]),
    .dir_valid(o_dv[2]), .held(o_held[2]), .key_event(o_ke[2]));

  // Reference model: pending prefix bytes, idle age, per-instance key sets (0=up..3=right).
  logic [7:0] pq [$];
  int         idle = 0;
  bit         hn [3][4];
  bit         he [3][4];
  int         cur [3];
  bit         kev [3];

  function automatic bit sticky_of(int m); return (m == 1); endfunction
  function automatic bit arrow_of(int m);  return (m != 2); endfunction

  function automatic int dir_of(bit ext, logic [7:0] c);
    if (ext) begin
      case (c)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
    case (c)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_clear();
    pq.delete();
    idle = 0;
    for (int m = 0; m < 3; m++) begin
      cur[m] = -1;
      kev[m] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        hn[m][k] = 1'b0;
        he[m][k] = 1'b0;
      end
    end
  endtask

  task automatic apply(int m, bit ext, bit brk, logic [7:0] code);
    int d;
    bit prev;
    d = dir_of(ext, code);
    if ((ext && !arrow_of(m)) || d < 0) return;
    prev = ext ? he[m][d] : hn[m][d];
    if (!brk) begin
      kev[m] = !prev;
      if (ext) he[m][d] = 1'b1; else hn[m][d] = 1'b1;
      cur[m] = d;
    end else if (prev) begin
      if (ext) he[m][d] = 1'b0; else hn[m][d] = 1'b0;
      if (!sticky_of(m) && cur[m] == d && !(hn[m][d] || he[m][d])) begin
        cur[m] = -1;
        for (int k = 0; k < 4; k++)
          if (cur[m] < 0 && (hn[m][k] || he[m][k])) cur[m] = k;
      end
    end
  endtask

  // Grammar of a complete sequence: (E0)* [F0] code, interpreted after each byte.
  task automatic model_byte(logic [7:0] b);
    int  i;
    bit  ext;
    bit  brk;
    pq.push_back(b);
    i = 0; ext = 1'b0; brk = 1'b0;
    while (i < pq.size() && pq[i] == 8'hE0) begin ext = 1'b1; i++; end
    if (i < pq.size() && pq[i] == 8'hF0) begin brk = 1'b1; i++; end
    if (i < pq.size()) begin
      for (int m = 0; m < 3; m++) apply(m, ext, brk, pq[i]);
      pq.delete();
    end
  endtask

  task automatic model_edge(logic v, logic [7:0] b);
    for (int m = 0; m < 3; m++) kev[m] = 1'b0;
    if (v) begin
      idle = 0;
      model_byte(b);
    end else if (pq.size() > 0) begin
      idle++;
      if (idle == TO) begin
        pq.delete();
        idle = 0;
      end
    end
  endtask

  function automatic logic [9:0] exp_of(int m);
    return {cur[m] == 0, cur[m] == 1, cur[m] == 2, cur[m] == 3, cur[m] >= 0,
            hn[m][0] | he[m][0], hn[m][1] | he[m][1], hn[m][2] | he[m][2],
            hn[m][3] | he[m][3], kev[m]};
  endfunction

  function automatic logic [9:0] act_of(int m);
    return {o_up[m], o_dn[m], o_lf[m], o_rt[m], o_dv[m], o_held[m], o_ke[m]};
  endfunction

  task automatic chk(string nm, int m, logic [9:0] act, logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%b want=%b", nm, m, $time, act, exp);
    end
  endtask

  task automatic cyc(logic v, logic [7:0] b);
    ps2_vld  = v;
    ps2_byte = b;
    @(posedge clk);
    model_edge(v, b);
    #1;
    for (int m = 0; m < 3; m++) chk("model", m, act_of(m), exp_of(m));
  endtask

  task automatic do_reset();
    ps2_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) chk("async_reset", m, act_of(m), 10'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic [9:0] e0;
    logic [9:0] e1;
  } vec_t;
  vec_t tbl [$];

  task automatic add(logic v, logic [7:0] b, logic [9:0] e0, logic [9:0] e1);
    vec_t r;
    r.v = v; r.b = b; r.e0 = e0; r.e1 = e1;
    tbl.push_back(r);
  endtask

  logic [7:0] pool [10];

  initial begin
    // {goup,godown,goleft,goright,dir_valid,held[3:0],key_event}; e0 hold mode, e1 sticky
    add(1'b1, 8'h1D, 10'b1000_1_1000_1, 10'b1000_1_1000_1);
    add(1'b1, 8'h1D, 10'b1000_1_1000_0, 10'b1000_1_1000_0);
    add(1'b0, 8'h00, 10'b1000_1_1000_0, 10'b1000_1_1000_0);
    add(1'b1, 8'h1D, 10'b1000_1_1000_0, 10'b1000_1_1000_0);
    add(1'b1, 8'h1B, 10'b0100_1_1100_1, 10'b0100_1_1100_1);
    add(1'b1, 8'hF0, 10'b0100_1_1100_0, 10'b0100_1_1100_0);
    add(1'b1, 8'h1B, 10'b1000_1_1000_0, 10'b0100_1_1000_0);
    add(1'b1, 8'hF0, 10'b1000_1_1000_0, 10'b0100_1_1000_0);
    add(1'b1, 8'h1D, 10'b0000_0_0000_0, 10'b0100_1_0000_0);
    add(1'b1, 8'h1C, 10'b0010_1_0010_1, 10'b0010_1_0010_1);
    add(1'b1, 8'hF0, 10'b0010_1_0010_0, 10'b0010_1_0010_0);
    add(1'b1, 8'h1C, 10'b0000_0_0000_0, 10'b0010_1_0000_0);
    add(1'b1, 8'h23, 10'b0001_1_0001_1, 10'b0001_1_0001_1);
    add(1'b1, 8'hE0, 10'b0001_1_0001_0, 10'b0001_1_0001_0);
    add(1'b1, 8'h6B, 10'b0010_1_0011_1, 10'b0010_1_0011_1);
    add(1'b1, 8'hE0, 10'b0010_1_0011_0, 10'b0010_1_0011_0);
    add(1'b1, 8'hF0, 10'b0010_1_0011_0, 10'b0010_1_0011_0);
    add(1'b1, 8'h6B, 10'b0001_1_0001_0, 10'b0010_1_0001_0);
    add(1'b1, 8'h1D, 10'b1000_1_1001_1, 10'b1000_1_1001_1);
    add(1'b1, 8'hE0, 10'b1000_1_1001_0, 10'b1000_1_1001_0);
    add(1'b1, 8'h75, 10'b1000_1_1001_1, 10'b1000_1_1001_1);
    add(1'b1, 8'hE0, 10'b1000_1_1001_0, 10'b1000_1_1001_0);
    add(1'b1, 8'hF0, 10'b1000_1_1001_0, 10'b1000_1_1001_0);
    add(1'b1, 8'h75, 10'b1000_1_1001_0, 10'b1000_1_1001_0);
    add(1'b1, 8'hF0, 10'b1000_1_1001_0, 10'b1000_1_1001_0);
    add(1'b1, 8'h1D, 10'b0001_1_0001_0, 10'b1000_1_0001_0);
    add(1'b1, 8'h72, 10'b0001_1_0001_0, 10'b1000_1_0001_0);
    add(1'b1, 8'hF0, 10'b0001_1_0001_0, 10'b1000_1_0001_0);
    add(1'b1, 8'h23, 10'b0000_0_0000_0, 10'b1000_1_0000_0);
    add(1'b1, 8'hF0, 10'b0000_0_0000_0, 10'b1000_1_0000_0);
    add(1'b1, 8'h23, 10'b0000_0_0000_0, 10'b1000_1_0000_0);

    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

    rst_n = 1'b0; ps2_vld = 1'b0; ps2_byte = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) chk("reset_state", m, act_of(m), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].b);
      chk("table_hold", i, act_of(0), tbl[i].e0);
      chk("table_sticky", i, act_of(1), tbl[i].e1);
    end

    // Byte on the timeout cycle still completes the break prefix.
    do_reset();
    cyc(1'b1, 8'hF0);
    repeat (TO - 1) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h1D);
    chk("timeout_edge_break", 0, {9'b0, o_up[0]}, 10'b0);
    // One more idle cycle and the prefix is gone, so the byte is a make.
    cyc(1'b1, 8'hF0);
    repeat (TO) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h1D);
    chk("timeout_expired_make", 0, {9'b0, o_up[0]}, 10'b1);

    // Reset inside EXT: 72 afterwards is an unmapped normal make.
    do_reset();
    cyc(1'b1, 8'h1D);
    cyc(1'b1, 8'hE0);
    do_reset();
    cyc(1'b1, 8'h72);
    chk("reset_drops_ext", 0, act_of(0), 10'b0);
    // Reset inside EXT_BRK: 1B afterwards is a normal make of down.
    cyc(1'b1, 8'hE0);
    cyc(1'b1, 8'hF0);
    do_reset();
    cyc(1'b1, 8'h1B);
    chk("reset_drops_extbrk", 0, {9'b0, o_dn[0]}, 10'b1);

    // Arrow codes ignored when disabled, accepted otherwise.
    do_reset();
    cyc(1'b1, 8'hE0);
    cyc(1'b1, 8'h75);
    chk("arrow_off", 2, {5'b0, o_dv[2], o_held[2]}, 10'b0);
    chk("arrow_on", 1, {5'b0, o_dv[1], o_held[1]}, 10'b00000_1_1000);

    // Random stream against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(TO - 2, TO + 2)) cyc(1'b0, 8'h00);
      end else if ($urandom_range(0, 9) == 0) begin
        cyc(1'b1, 8'($urandom_range(0, 255)));
      end else begin
        cyc(1'($urandom_range(0, 1)), pool[$urandom_range(0, 9)]);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
